// File: rtl/dmem_bus_if.sv
// Data-memory bus bridge: one outstanding req/ack transaction per M-stage access.
// Optional bus-wait abandonment is compiled in with `define DMEM_TIMEOUT_EN.
module dmem_bus_if #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        BusReq,
  output logic        BusWE,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  input  logic [31:0] BusRData,
  input  logic        BusAck
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   access;
  logic   aligned;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dmem_bus_if: TIMEOUT must be 2..255");
  end

  assign access  = MemWrite | MemRead;
  assign aligned = (Addr[1:0] == 2'b00);

  // Combinational so the core freezes in the very cycle the access appears.
  assign Stall = Reset_n &
                 (((state == IDLE) & access) | (state == BUSY));

`ifdef DMEM_TIMEOUT_EN
  localparam logic [7:0] TLast = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`endif

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      ReadData <= '0;
      Fault    <= 1'b0;
      BusReq   <= 1'b0;
      BusWE    <= 1'b0;
      BusAddr  <= '0;
      BusWData <= '0;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (access && aligned) begin
            BusAddr  <= Addr;
            BusWData <= WriteData;
            BusWE    <= MemWrite;
            BusReq   <= 1'b1;
            state    <= BUSY;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else if (access) begin
            ReadData <= '0;
            Fault    <= 1'b1;
            state    <= DONE;
          end
        end
        BUSY: begin
          if (BusAck) begin
            BusReq <= 1'b0;
            if (!BusWE) ReadData <= BusRData;
            state  <= DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (wait_cnt == TLast) begin
            BusReq <= 1'b0;
            if (!BusWE) ReadData <= 32'hDEAD_BEEF;
            Fault  <= 1'b1;
            state  <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          // Inputs here belong to the access just serviced; never re-issue.
          Fault <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Randomized bench for dmem_bus_if against a transaction-level model.
// Define DMEM_TIMEOUT_EN to also exercise bus-wait abandonment (TIMEOUT=4).
module tb_dmem_bus_if;

  localparam int T = 4;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        MemWrite, MemRead;
  logic [31:0] Addr, WriteData;
  logic [31:0] ReadData;
  logic        Stall, Fault;
  logic        BusReq, BusWE;
  logic [31:0] BusAddr, BusWData;
  logic [31:0] BusRData;
  logic        BusAck;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rd;

  dmem_bus_if #(.TIMEOUT(T)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .Addr(Addr), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .Fault(Fault),
    .BusReq(BusReq), .BusWE(BusWE),
    .BusAddr(BusAddr), .BusWData(BusWData),
    .BusRData(BusRData), .BusAck(BusAck)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    Addr     = $urandom;
    WriteData = $urandom;
  endtask

  // lat: BusReq cycle carrying BusAck (1-based); 0 means never ack.
  task automatic do_access(input logic we, input logic rd,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int lat, input logic [31:0] rdata);
    bit mis, timed, is_rd;
    int n;
    mis   = (a[1:0] != 2'b00);
    is_rd = rd && !we;
    MemWrite  = we;
    MemRead   = rd;
    Addr      = a;
    WriteData = wd;
    BusAck    = $urandom_range(0, 1);
    BusRData  = $urandom;
    @(negedge CLK);
    chk("c0_stall", Stall, 1);
    chk("c0_req", BusReq, 0);
    timed = 0;
    n = lat;
`ifdef DMEM_TIMEOUT_EN
    if (lat == 0 || lat > T) begin
      timed = 1;
      n = T;
    end
`endif
    if (!mis) begin
      for (int i = 1; i <= n; i++) begin
        nxt();
        BusAck   = (i == lat);
        BusRData = (i == lat) ? rdata : $urandom;
        @(negedge CLK);
        chk("busy_req", BusReq, 1);
        chk("busy_stall", Stall, 1);
        chk("busy_addr", BusAddr, a);
        chk("busy_we", BusWE, we);
        chk("busy_wdata", BusWData, wd);
        chk("busy_fault", Fault, 0);
      end
    end
    nxt();
    BusAck   = $urandom_range(0, 1);
    BusRData = $urandom;
    if (mis) exp_rd = 32'h0;
    else if (is_rd) exp_rd = timed ? 32'hDEAD_BEEF : rdata;
    @(negedge CLK);
    chk("done_stall", Stall, 0);
    chk("done_req", BusReq, 0);
    chk("done_fault", Fault, (mis || timed) ? 1 : 0);
    chk("done_rdata", ReadData, exp_rd);
    nxt();
    BusAck = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0;
    BusAck = 1'b0;
    BusRData = '0;
    idle_inputs();
    MemRead = 1'b1;
    #1;
    chk("rst_stall", Stall, 0);
    chk("rst_req", BusReq, 0);
    chk("rst_rdata", ReadData, 0);
    chk("rst_fault", Fault, 0);
    chk("rst_addr", BusAddr, 0);
    chk("rst_we", BusWE, 0);
    chk("rst_wdata", BusWData, 0);
    exp_rd = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;
    idle_inputs();
    nxt();

    do_access(0, 1, 32'h100, 32'h0, 1, 32'h1234_5678);
    do_access(1, 0, 32'h204, 32'hA5A5_A5A5, 5, 32'hFFFF_FFFF);
    do_access(0, 1, 32'h103, 32'h0, 1, 32'h1111_1111);
    do_access(0, 1, 32'h300, 32'h0, 2, 32'hCAFE_0001);
    do_access(1, 0, 32'h304, 32'h5555_AAAA, 1, 32'h0);
    do_access(1, 1, 32'h308, 32'h7777_0000, 3, 32'h9999_9999);

    // Reset mid-transaction.
    MemRead = 1'b1;
    Addr = 32'h40;
    repeat (3) nxt();
    #2;
    Reset_n = 1'b0;
    #1;
    chk("ar_req", BusReq, 0);
    chk("ar_stall", Stall, 0);
    chk("ar_rdata", ReadData, 0);
    chk("ar_addr", BusAddr, 0);
    exp_rd = 32'h0;
    idle_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;
    chk("ar_idle_stall", Stall, 0);
    nxt();
    do_access(0, 1, 32'h44, 32'h0, 1, 32'h0BAD_F00D);

`ifdef DMEM_TIMEOUT_EN
    do_access(0, 1, 32'h500, 32'h0, 0, 32'h0);
    do_access(0, 1, 32'h504, 32'h0, T, 32'h2468_ACE0);
    do_access(1, 0, 32'h508, 32'h1357_9BDF, 0, 32'h0);
`endif

    for (int k = 0; k < 200; k++) begin
      logic we, rd;
      logic [31:0] a;
      int lat;
      int gap;
      we = $urandom_range(0, 1);
      rd = we ? $urandom_range(0, 1) : 1'b1;
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
`ifdef DMEM_TIMEOUT_EN
      lat = $urandom_range(0, T + 2);
`else
      lat = $urandom_range(1, 7);
`endif
      do_access(we, rd, a, $urandom, lat, $urandom);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        idle_inputs();
        BusAck = $urandom_range(0, 1);
        @(negedge CLK);
        chk("gap_stall", Stall, 0);
        chk("gap_req", BusReq, 0);
        chk("gap_rdata", ReadData, exp_rd);
        nxt();
      end
      BusAck = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
